axis_frame_buffer: RTL and testbench
====================================

AXIS_FRAME_BUFFER -- requirements
Module: axis_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stream and read-data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, storage depth in words; power of two, minimum 4.
REQ-003 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port s_axis_tdata, input, DATA_W, stream word from the accelerator master.
REQ-006 SHALL have port s_axis_tvalid, input, 1, upstream word valid.
REQ-007 SHALL have port s_axis_tlast, input, 1, last word of frame.
REQ-008 SHALL have port s_axis_tready, output, 1, buffer can accept a word.
REQ-009 SHALL have port clear, input, 1, synchronous flush of contents and state.
REQ-010 SHALL have port rd_en, input, 1, host read request.
REQ-011 SHALL have port rd_data, output, DATA_W, registered read word.
REQ-012 SHALL have port rd_valid, output, 1, one-cycle pulse qualifying rd_data.
REQ-013 SHALL have port count, output, log2(DEPTH)+1, words currently stored.
REQ-014 SHALL have port empty, output, 1, count == 0.
REQ-015 SHALL have port frame_done, output, 1, a complete frame is held.
REQ-016 SHALL have port frame_len, output, log2(DEPTH)+1, word count of the held frame.

Function
REQ-017 SHALL store words in a circular buffer with log2(DEPTH)+1-bit write/read pointers; pointers SHALL wrap modulo 2*DEPTH; full = MSBs differ and lower bits equal.
REQ-018 SHALL implement states IDLE, RECV and HOLD.
REQ-019 In IDLE: s_axis_tready=1; accepting a word without tlast SHALL go to RECV; accepting a word with tlast SHALL go to HOLD.
REQ-020 In RECV: s_axis_tready = !full; accepting a word with tlast SHALL go to HOLD; when full, the block SHALL apply backpressure and never drop or overwrite data.
REQ-021 In HOLD: s_axis_tready=0 and frame_done=1; the transition to IDLE SHALL occur on the cycle the final stored word is read.
REQ-022 A word SHALL be written only on s_axis_tvalid & s_axis_tready.
REQ-023 Reads SHALL be allowed in every state; rd_en & !empty SHALL pop one word, with rd_data updated and rd_valid=1 on the next cycle (latency 1).
REQ-024 rd_en while empty SHALL be ignored: no pointer change, rd_valid=0, rd_data held.
REQ-025 A simultaneous write and read SHALL leave count unchanged and both SHALL succeed; at full, only the read occurs because tready is 0.
REQ-026 count SHALL equal the write pointer minus the read pointer, modulo 2*DEPTH.
REQ-027 clear SHALL, on the next edge, zero both pointers, enter IDLE, and deassert rd_valid; clear SHALL take priority over a simultaneous write or read; rd_data SHALL be held.

Reset
REQ-028 Asserting rst_n low SHALL immediately force: state IDLE, pointers 0, rd_data 0, rd_valid 0, frame_len 0; count=0, empty=1, frame_done=0, s_axis_tready=0.
REQ-029 s_axis_tready SHALL rise no earlier than the first clk edge after rst_n deasserts.
REQ-030 Reset mid-frame SHALL discard all stored words; storage contents need not be cleared.

Configuration
REQ-031 With AXIS_FRAME_BUFFER_LEN_EN defined: the block SHALL count accepted words per frame; frame_len SHALL be loaded with the count including the tlast word on entry to HOLD, held through HOLD, and cleared on return to IDLE, reset or clear.
REQ-032 Without AXIS_FRAME_BUFFER_LEN_EN: frame_len SHALL be tied to 0 and no frame counter SHALL be synthesised; all other behaviour SHALL be unchanged.

Verification
REQ-033 Frame of 5 words 0x1..0x5 with tlast on 0x5, then 5 rd_en: frame_done=1 and count=5 after the tlast word, frame_len=5 when enabled; rd_data 0x1..0x5 in order, each with a single rd_valid pulse; then IDLE and empty=1.
REQ-034 Stream 20 words with tlast on word 20, DEPTH=16, no reads: tready=0 at count=16; one read reopens tready; all 20 words are read back in order with no loss.
REQ-035 Read and write in the same cycle at count=7 in RECV: count stays 7 and FIFO order is preserved across the pointer wrap.
REQ-036 rd_en on an empty buffer: no rd_valid and count stays 0; tvalid during HOLD: tready=0 and the word is not written.
REQ-037 Assert clear in the same cycle as a write at count=3: count=0 and empty=1 next cycle, state IDLE, the write is discarded.
REQ-038 Pull rst_n low mid-frame (count=4): outputs reach reset values immediately; after release, a new 2-word frame passes correctly.

Source files
------------

// File: rtl/axis_frame_buffer.sv
// Single-frame AXI-Stream capture buffer with host read port.
// Optional per-frame word counter enabled by defining AXIS_FRAME_BUFFER_LEN_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame in progress; buffer empty; ready for first word
// RECV  | frame in progress; accepting words while not full
// HOLD  | complete frame held; input closed until the last word is read
module axis_frame_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    input  logic                     clear,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   frame_len
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              run;
    logic              full;
    logic              wr_fire;
    logic              rd_fire;
    logic              hold_exit;
    logic [DATA_W-1:0] mem [DEPTH];

    assign count      = wr_ptr - rd_ptr;
    assign empty      = (count == '0);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign frame_done = (state == HOLD);

    // run keeps tready low until the first edge after reset release
    assign s_axis_tready = run && ((state == IDLE) || ((state == RECV) && !full));

    assign wr_fire   = s_axis_tvalid && s_axis_tready;
    assign rd_fire   = rd_en && !empty;
    assign hold_exit = (state == HOLD) && rd_fire && (count == (AW+1)'(1));

    always_ff @(posedge clk) begin
        if (wr_fire && !clear) begin
            mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            run      <= 1'b0;
        end else begin
            run <= 1'b1;
            if (clear) begin
                state    <= IDLE;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_fire;
                if (wr_fire) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_fire) begin
                    rd_data <= mem[rd_ptr[AW-1:0]];
                    rd_ptr  <= rd_ptr + 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (wr_fire) begin
                            state <= s_axis_tlast ? HOLD : RECV;
                        end
                    end
                    RECV: begin
                        if (wr_fire && s_axis_tlast) begin
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (hold_exit) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef AXIS_FRAME_BUFFER_LEN_EN
    logic [AW:0] frame_cnt;
    logic [AW:0] frame_cnt_inc;

    // saturate so an overlong frame reports the maximum rather than wrapping
    assign frame_cnt_inc = (&frame_cnt) ? frame_cnt : frame_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            frame_len <= '0;
        end else if (clear) begin
            frame_cnt <= '0;
            frame_len <= '0;
        end else begin
            if (wr_fire) begin
                if (s_axis_tlast) begin
                    frame_len <= frame_cnt_inc;
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= frame_cnt_inc;
                end
            end else if (hold_exit) begin
                frame_len <= '0;
            end
        end
    end
`else
    assign frame_len = '0;
`endif

endmodule

// File: tb/tb_axis_frame_buffer.sv
// Directed bench for axis_frame_buffer; read data checked through a scoreboard queue.
module tb_axis_frame_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic              clear;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [4:0]        count;
    logic              empty;
    logic              frame_done;
    logic [4:0]        frame_len;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q[$];

    axis_frame_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .clear        (clear),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .empty        (empty),
        .frame_done   (frame_done),
        .frame_len    (frame_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] flen(input int n);
`ifdef AXIS_FRAME_BUFFER_LEN_EN
        return 5'(n);
`else
        return 5'(0 * n);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d, input logic last);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        while (!s_axis_tready && n < 50) begin
            cycle();
            n++;
        end
        checks++;
        if (n == 50) begin
            errors++;
            $display("FAIL write_timeout: word %0h not accepted, tready=%0b expected 1", d, s_axis_tready);
        end else begin
            cycle();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] exp);
        rd_en = 1'b1;
        exp_q.push_back(exp);
        cycle();
        rd_en = 1'b0;
    endtask

    // monitor: every rd_valid pulse must match the next expected word
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: rd_valid with data %0h, expected no read", rd_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        errors++;
                        $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        clear = 1'b0; rd_en = 1'b0;
        #1;
        check("rst_tready", s_axis_tready, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_frame_done", frame_done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_frame_len", frame_len, 0);
        cycle(); cycle();
        rst_n = 1'b1;
        check("tready_before_edge", s_axis_tready, 0);
        cycle();
        check("tready_after_edge", s_axis_tready, 1);

        // 5-word frame, write attempt in HOLD, then drain
        for (int i = 1; i <= 5; i++) write_word(i, i == 5);
        check("f5_frame_done", frame_done, 1);
        check("f5_count", count, 5);
        check("f5_frame_len", frame_len, flen(5));
        s_axis_tdata = 32'hDEAD; s_axis_tvalid = 1'b1;
        check("hold_tready", s_axis_tready, 0);
        cycle();
        s_axis_tvalid = 1'b0;
        check("hold_count", count, 5);
        for (int i = 1; i <= 5; i++) read_word(i);
        check("f5_empty", empty, 1);
        check("f5_idle_done", frame_done, 0);
        check("f5_idle_tready", s_axis_tready, 1);
        check("f5_len_cleared", frame_len, 0);

        // read while empty
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("empty_rd_valid", rd_valid, 0);
        check("empty_count", count, 0);
        check("empty_rd_data_held", rd_data, 5);

        // 20-word frame against a 16-deep buffer
        for (int i = 0; i < 16; i++) write_word(32'h100 + i, 1'b0);
        s_axis_tdata = 32'h110; s_axis_tvalid = 1'b1;
        check("full_count", count, 16);
        check("full_tready", s_axis_tready, 0);
        cycle();
        check("full_no_write", count, 16);
        read_word(32'h100);
        check("reopen_tready", s_axis_tready, 1);
        write_word(32'h110, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            read_word(32'h100 + k);
            write_word(32'h110 + k, k == 3);
        end
        check("f20_count", count, 16);
        check("f20_frame_done", frame_done, 1);
        check("f20_frame_len", frame_len, flen(20));
        for (int k = 4; k < 20; k++) read_word(32'h100 + k);
        check("f20_empty", empty, 1);
        check("f20_idle", frame_done, 0);

        // simultaneous read/write at count 7 across the pointer wrap
        for (int i = 0; i < 7; i++) write_word(32'h200 + i, 1'b0);
        check("rw_count_pre", count, 7);
        for (int k = 0; k < 12; k++) begin
            s_axis_tdata = 32'h207 + k; s_axis_tvalid = 1'b1; rd_en = 1'b1;
            exp_q.push_back(32'h200 + k);
            cycle();
            check("rw_count", count, 7);
        end
        s_axis_tvalid = 1'b0; rd_en = 1'b0;
        write_word(32'h213, 1'b1);
        check("rw_count_hold", count, 8);
        check("rw_frame_len", frame_len, flen(20));
        for (int k = 12; k < 20; k++) read_word(32'h200 + k);
        check("rw_empty", empty, 1);

        // clear colliding with a write at count 3
        for (int i = 0; i < 3; i++) write_word(32'h300 + i, 1'b0);
        check("clr_count_pre", count, 3);
        s_axis_tdata = 32'h303; s_axis_tvalid = 1'b1; clear = 1'b1;
        cycle();
        s_axis_tvalid = 1'b0; clear = 1'b0;
        check("clr_count", count, 0);
        check("clr_empty", empty, 1);
        check("clr_done", frame_done, 0);
        check("clr_tready", s_axis_tready, 1);
        check("clr_frame_len", frame_len, 0);
        write_word(32'h3AA, 1'b1);
        check("clr_new_count", count, 1);
        check("clr_new_len", frame_len, flen(1));
        read_word(32'h3AA);
        check("clr_new_empty", empty, 1);

        // reset in the middle of a frame
        for (int i = 0; i < 4; i++) write_word(32'h400 + i, 1'b0);
        check("mid_count", count, 4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_tready", s_axis_tready, 0);
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_done", frame_done, 0);
        cycle();
        rst_n = 1'b1;
        check("mid_rel_tready", s_axis_tready, 0);
        cycle();
        write_word(32'h500, 1'b0);
        write_word(32'h501, 1'b1);
        check("post_rst_count", count, 2);
        check("post_rst_done", frame_done, 1);
        check("post_rst_len", frame_len, flen(2));
        read_word(32'h500);
        read_word(32'h501);
        check("post_rst_empty", empty, 1);

        cycle(); cycle();
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
